div_float: RTL and testbench
============================

// Module: div_float
// PURPOSE
//   Iterative IEEE-754 single-precision divider, c = a / b. It is the inverse
//   of the existing float multiplier and sits beside it in the arithmetic unit.
//   Restoring division retires one quotient bit per cycle, followed by round-to-
//   nearest-even. A start/busy/done handshake gives a fixed 28-cycle latency.
// PARAMETERS
//   QBITS  26  quotient bits: 24 mantissa + guard + round; fixes the latency
// PORTS
//   clk          in   1   clock, rising edge
//   rst_n        in   1   asynchronous active-low reset
//   start        in   1   request; accepted only in IDLE
//   a            in   32  dividend, IEEE-754 single
//   b            in   32  divisor, IEEE-754 single
//   busy         out  1   high while an operation is in flight
//   done         out  1   one-cycle pulse: c/flags valid
//   c            out  32  quotient
//   overflow     out  1   result exponent >= 255, so c = +/-inf
//   div_by_zero  out  1   finite nonzero a divided by zero
// BEHAVIOUR
// - Reset, async, any state: state=IDLE; busy, done, c, overflow, div_by_zero = 0.
// - FSM: IDLE -> DIV -> ROUND -> IDLE. Latency is fixed for every input.
//     Edge 0: start=1 in IDLE. Latch a/b, unpack, clear remainder. busy=1.
//     Edges 1..26: DIV, one restoring step per edge. rem-mb >= 0 -> bit 1, keep diff.
//     Edge 27: ROUND. Normalise, round, pack, apply specials.
//     After edge 28: done=1 for exactly one cycle with c/flags valid, busy=0.
// - start while busy is ignored. Operand changes after edge 0 are ignored.
//   start=1 in the done cycle is accepted: the next op begins at that edge.
// - c/overflow/div_by_zero hold until the next result is written.
// - Mantissas: ma={1,a[22:0]}, mb={1,b[22:0]}. q = floor(ma*2^25/mb), 26 bits.
//     q[25]=1: mant=q[24:2], g=q[1], s=q[0] | (rem!=0), e=ea-eb+127.
//     else:    mant=q[23:1], g=q[0], s=(rem!=0),         e=ea-eb+126.
// - Round: +1 ulp if g & (s | mant[0]). Mantissa carry-out -> mant=0, e=e+1.
// - Exponent is 10-bit signed. e >= 255 -> c=sign|0x7F800000, overflow=1.
//   e <= 0 -> c=sign|0x00000000 (flush to zero, no flag).
// - Special classes: exp==0 is zero (denormals flushed); exp==255 is inf/NaN.
//   Specials have priority over the arithmetic path:
//     NaN in a or b, 0/0, inf/inf -> 0x7FC00000
//     finite nonzero / 0          -> +/-inf, div_by_zero=1
//     inf / (finite or 0)         -> +/-inf
//     0 / nonzero, finite / inf   -> +/-0
// - Sign is a[31]^b[31] on every non-NaN result.
// - Reset mid-operation aborts it: no done pulse, outputs zeroed.
// TESTING
//   1. 0x40C00000 / 0x40000000 (6/2): c=0x40400000, done after edge 28 only.
//   2. 0x3F800000 / 0x40400000 (1/3): c=0x3EAAAAAB (round-up path).
//   3. 0xBF800000 / 0x00000000: c=0xFF800000, div_by_zero=1, overflow=0.
//      0/0 -> c=0x7FC00000.
//   4. 0x7F000000 / 0x00800000: c=0x7F800000, overflow=1.
//      0x00800000 / 0x7F000000: c=0x00000000.
//   5. start pulsed at edges 5 and 12 of an op: ignored, one done only.
//      start held high in the done cycle: back-to-back op, next done 28 later.
//   6. rst_n low at edge 10: busy=0, c=0, no done. New op after release: correct.

Source files
------------

// File: rtl/div_float.sv
// Iterative IEEE-754 single-precision divider (c = a / b). Restoring division
// produces one quotient bit per cycle, then round-to-nearest-even and packing.
module div_float #(
  parameter int QBITS = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] c,
  output logic        overflow,
  output logic        div_by_zero
);
  localparam int CW = $clog2(QBITS);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DIV   = 2'd1;
  localparam logic [1:0] ROUND = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic             phase;
  logic [31:0]      ra, rb;
  logic [24:0]      rem;
  logic [QBITS-1:0] q;
  logic [31:0]      res_c;
  logic             res_ov, res_dz;
  logic [31:0]      nxt_c;
  logic             nxt_ov, nxt_dz;

  // restoring step: remainder stays below 2*mb, so 25 bits suffice
  logic [23:0] mb;
  logic [24:0] sub, sel;
  logic        ge;
  always_comb begin
    mb  = {1'b1, rb[22:0]};
    ge  = rem >= {1'b0, mb};
    sub = rem - {1'b0, mb};
    sel = ge ? sub : rem;
  end

  logic        sign, a_z, b_z, a_inf, b_inf, a_nan, b_nan;
  logic [22:0] mant;
  logic        g, s, rnd;
  logic [23:0] mant_r;
  logic signed [9:0] e_n, e_fin;
  always_comb begin
    sign  = ra[31] ^ rb[31];
    a_z   = ra[30:23] == 8'h00;
    b_z   = rb[30:23] == 8'h00;
    a_inf = (ra[30:23] == 8'hFF) && (ra[22:0] == 23'd0);
    b_inf = (rb[30:23] == 8'hFF) && (rb[22:0] == 23'd0);
    a_nan = (ra[30:23] == 8'hFF) && (ra[22:0] != 23'd0);
    b_nan = (rb[30:23] == 8'hFF) && (rb[22:0] != 23'd0);

    e_n = $signed({2'b00, ra[30:23]}) - $signed({2'b00, rb[30:23]});
    if (q[25]) begin
      mant = q[24:2];
      g    = q[1];
      s    = q[0] | (rem != 25'd0);
      e_n  = e_n + 10'sd127;
    end else begin
      mant = q[23:1];
      g    = q[0];
      s    = rem != 25'd0;
      e_n  = e_n + 10'sd126;
    end
    rnd    = g & (s | mant[0]);
    mant_r = {1'b0, mant} + {23'd0, rnd};
    // carry-out leaves mant_r[22:0] at zero, only the exponent moves
    e_fin  = e_n + {9'd0, mant_r[23]};

    nxt_ov = 1'b0;
    nxt_dz = 1'b0;
    if (e_fin >= 10'sd255) begin
      nxt_c  = {sign, 8'hFF, 23'd0};
      nxt_ov = 1'b1;
    end else if (e_fin <= 10'sd0) begin
      nxt_c  = {sign, 31'd0};
    end else begin
      nxt_c  = {sign, e_fin[7:0], mant_r[22:0]};
    end

    if (a_nan || b_nan || (a_z && b_z) || (a_inf && b_inf)) begin
      nxt_c  = 32'h7FC0_0000;
      nxt_ov = 1'b0;
    end else if (b_z) begin
      nxt_c  = {sign, 8'hFF, 23'd0};
      nxt_ov = 1'b0;
      nxt_dz = !a_inf;
    end else if (a_inf) begin
      nxt_c  = {sign, 8'hFF, 23'd0};
      nxt_ov = 1'b0;
    end else if (a_z || b_inf) begin
      nxt_c  = {sign, 31'd0};
      nxt_ov = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      phase       <= 1'b0;
      ra          <= '0;
      rb          <= '0;
      rem         <= '0;
      q           <= '0;
      res_c       <= '0;
      res_ov      <= 1'b0;
      res_dz      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      c           <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          ra    <= a;
          rb    <= b;
          rem   <= {1'b0, 1'b1, a[22:0]};
          q     <= '0;
          cnt   <= '0;
          busy  <= 1'b1;
          state <= DIV;
        end
        DIV: begin
          q   <= {q[QBITS-2:0], ge};
          rem <= sel << 1;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(QBITS - 1)) begin
            phase <= 1'b0;
            state <= ROUND;
          end
        end
        ROUND: begin
          // two edges: compute/pack, then publish with the done pulse
          if (!phase) begin
            res_c  <= nxt_c;
            res_ov <= nxt_ov;
            res_dz <= nxt_dz;
            phase  <= 1'b1;
          end else begin
            c           <= res_c;
            overflow    <= res_ov;
            div_by_zero <= res_dz;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_float.sv
// Directed bench for div_float: latency, rounding, specials, handshake, reset.
module tb_div_float;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, overflow, div_by_zero;
  logic [31:0] c;
  int total = 0;
  int passed = 0;
  int failed = 0;

  div_float #(.QBITS(26)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .c(c), .overflow(overflow),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // edge 0: start sampled in IDLE
  task automatic launch(input logic [31:0] va, input logic [31:0] vb);
    @(negedge clk);
    a = va; b = vb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 32'hDEAD_BEEF; b = 32'h1234_5678;
  endtask

  // edges 1..28, optional stray start pulses at edges 5 and 12
  task automatic finish_op(input string tag, input logic [31:0] ec,
                           input logic eo, input logic ez, input bit pulse);
    int early;
    early = 0;
    for (int e = 1; e <= 27; e++) begin
      if (pulse && (e == 5 || e == 12)) begin
        @(negedge clk);
        start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (done) early++;
      if (e == 1) check({tag, " busy"}, {31'd0, busy}, 32'd1);
    end
    check({tag, " early_done"}, early, 32'd0);
    @(posedge clk); #1;
    check({tag, " done"}, {31'd0, done}, 32'd1);
    check({tag, " busy_low"}, {31'd0, busy}, 32'd0);
    check({tag, " c"}, c, ec);
    check({tag, " ovf"}, {31'd0, overflow}, {31'd0, eo});
    check({tag, " dbz"}, {31'd0, div_by_zero}, {31'd0, ez});
  endtask

  task automatic op(input string tag, input logic [31:0] va, input logic [31:0] vb,
                    input logic [31:0] ec, input logic eo, input logic ez);
    launch(va, vb);
    finish_op(tag, ec, eo, ez, 1'b0);
    @(posedge clk); #1;
    check({tag, " done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int seen;
    #12;
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst c", c, 32'd0);
    check("rst flags", {30'd0, overflow, div_by_zero}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    op("6/2",      32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 1'b0);
    op("1/3",      32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 1'b0, 1'b0);
    op("-1/0",     32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 1'b0, 1'b1);
    op("0/0",      32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b0, 1'b0);
    op("ovf",      32'h7F00_0000, 32'h0080_0000, 32'h7F80_0000, 1'b1, 1'b0);
    op("unf",      32'h0080_0000, 32'h7F00_0000, 32'h0000_0000, 1'b0, 1'b0);
    op("max/1",    32'h7F7F_FFFF, 32'h3F80_0000, 32'h7F7F_FFFF, 1'b0, 1'b0);
    op("minnorm",  32'h0080_0000, 32'h3F80_0000, 32'h0080_0000, 1'b0, 1'b0);
    op("inf/2",    32'h7F80_0000, 32'h4000_0000, 32'h7F80_0000, 1'b0, 1'b0);
    op("2/inf",    32'h4000_0000, 32'h7F80_0000, 32'h0000_0000, 1'b0, 1'b0);
    op("nan/1",    32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 1'b0, 1'b0);
    op("inf/inf",  32'hFF80_0000, 32'h7F80_0000, 32'h7FC0_0000, 1'b0, 1'b0);
    op("-0/2",     32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 1'b0, 1'b0);
    op("2/-0",     32'h4000_0000, 32'h8000_0000, 32'hFF80_0000, 1'b0, 1'b1);

    // stray starts ignored, then back-to-back from the done cycle
    launch(32'h3F80_0000, 32'h3F80_0000);
    finish_op("1/1 pulsed", 32'h3F80_0000, 1'b0, 1'b0, 1'b1);
    a = 32'hC0C0_0000; b = 32'h4000_0000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    finish_op("b2b -6/2", 32'hC040_0000, 1'b0, 1'b0, 1'b0);

    // reset at edge 10 aborts the op
    launch(32'h40C0_0000, 32'h4000_0000);
    repeat (9) @(posedge clk);
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort c", c, 32'd0);
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) seen++;
      if (!rst_n && $time > 0) begin
        @(negedge clk); rst_n = 1'b1;
      end
    end
    check("abort no_done", seen, 32'd0);
    op("after rst", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
